// File: rtl/formula_loader.sv
// formula_loader: packs a valid/ready CNF literal stream into a flat formula, drives the SAT
// kernel with find and holds its verdict until done_ack. Optional macro: LOADER_CYCLE_CNT_EN.
module formula_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_CLAUSES    = 10,
  parameter int unsigned MAX_LITS       = 5
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   lit_valid,
  output logic                                   lit_ready,
  input  logic [3:0]                             lit_in,
  input  logic                                   lit_eoc,
  input  logic                                   lit_eof,
  output logic                                   find,
  output logic [MAX_CLAUSES*(4*MAX_LITS+3)+3:0]  out_formula,
  input  logic                                   kernel_ended,
  input  logic                                   kernel_sat,
  input  logic                                   kernel_unsat,
  output logic                                   done,
  output logic                                   result_sat,
  output logic                                   result_unsat,
  output logic [2:0]                             err_code,
  input  logic                                   done_ack
`ifdef LOADER_CYCLE_CNT_EN
  ,
  output logic [15:0]                            solve_cycles
`endif
);

  // Layout, LSB first: formula count[3:0], then clause c at bit 4+ClauseW*c holding its
  // count[2:0] followed by literal l at offset 3+4*l. Literal = {var[2:0], polarity}.
  localparam int unsigned ClauseW  = 4 * MAX_LITS + 3;
  localparam int unsigned FormulaW = MAX_CLAUSES * ClauseW + 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StSolve = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [2:0] ErrNone       = 3'd0;
  localparam logic [2:0] ErrBadVar     = 3'd1;
  localparam logic [2:0] ErrClauseOvf  = 3'd2;
  localparam logic [2:0] ErrFormulaOvf = 3'd3;
  localparam logic [2:0] ErrTimeout    = 3'd4;
  localparam logic [2:0] ErrProto      = 3'd5;

  logic [1:0]          state_q, state_d;
  logic [FormulaW-1:0] formula_q, formula_d;
  logic [3:0]          clause_idx_q, clause_idx_d;
  logic [2:0]          lit_idx_q, lit_idx_d;
  logic                find_q, find_d;
  logic                done_q, done_d;
  logic                res_sat_q, res_sat_d;
  logic                res_unsat_q, res_unsat_d;
  logic [2:0]          err_q, err_d;
  logic [31:0]         tmo_q, tmo_d;
`ifdef LOADER_CYCLE_CNT_EN
  logic [15:0]         cyc_q, cyc_d;
`endif

  logic       accept;
  logic [2:0] tok_err;

  assign lit_ready = (state_q == StIdle) || (state_q == StLoad);
  assign accept    = lit_valid & lit_ready;

  always_comb begin
    state_d      = state_q;
    formula_d    = formula_q;
    clause_idx_d = clause_idx_q;
    lit_idx_d    = lit_idx_q;
    find_d       = find_q;
    done_d       = done_q;
    res_sat_d    = res_sat_q;
    res_unsat_d  = res_unsat_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
`ifdef LOADER_CYCLE_CNT_EN
    cyc_d        = cyc_q;
`endif

    tok_err = ErrNone;
    if (lit_in[3:1] == 3'd0) begin
      tok_err = ErrBadVar;
    end else if (32'(lit_idx_q) == MAX_LITS) begin
      tok_err = ErrClauseOvf;
    end else if (32'(clause_idx_q) == MAX_CLAUSES) begin
      tok_err = ErrFormulaOvf;
    end

    case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          if (tok_err != ErrNone) begin
            // Offending token is dropped; the partial formula stays visible until acked.
            err_d   = tok_err;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            for (int unsigned c = 0; c < MAX_CLAUSES; c++) begin
              if (32'(clause_idx_q) == c) begin
                for (int unsigned l = 0; l < MAX_LITS; l++) begin
                  if (32'(lit_idx_q) == l) begin
                    formula_d[4 + ClauseW*c + 3 + 4*l +: 4] = lit_in;
                  end
                end
                if (lit_eoc || lit_eof) begin
                  formula_d[4 + ClauseW*c +: 3] = lit_idx_q + 3'd1;
                end
              end
            end
            if (lit_eoc || lit_eof) begin
              lit_idx_d    = 3'd0;
              clause_idx_d = clause_idx_q + 4'd1;
            end else begin
              lit_idx_d = lit_idx_q + 3'd1;
            end
            if (lit_eof) begin
              formula_d[3:0] = clause_idx_q + 4'd1;
              state_d        = StSolve;
              find_d         = 1'b1;
              tmo_d          = 32'd0;
`ifdef LOADER_CYCLE_CNT_EN
              cyc_d          = 16'd0;
`endif
            end else begin
              state_d = StLoad;
            end
          end
        end
      end

      StSolve: begin
`ifdef LOADER_CYCLE_CNT_EN
        if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`endif
        // A verdict on the timeout edge takes precedence over the timeout.
        if (kernel_ended) begin
          res_sat_d   = kernel_sat;
          res_unsat_d = kernel_unsat;
          err_d       = (kernel_sat == kernel_unsat) ? ErrProto : ErrNone;
          find_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          err_d   = ErrTimeout;
          find_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      StDone: begin
        if (done_ack) begin
          state_d      = StIdle;
          formula_d    = '0;
          clause_idx_d = 4'd0;
          lit_idx_d    = 3'd0;
          done_d       = 1'b0;
          res_sat_d    = 1'b0;
          res_unsat_d  = 1'b0;
          err_d        = ErrNone;
`ifdef LOADER_CYCLE_CNT_EN
          cyc_d        = 16'd0;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      formula_q    <= '0;
      clause_idx_q <= 4'd0;
      lit_idx_q    <= 3'd0;
      find_q       <= 1'b0;
      done_q       <= 1'b0;
      res_sat_q    <= 1'b0;
      res_unsat_q  <= 1'b0;
      err_q        <= ErrNone;
      tmo_q        <= 32'd0;
`ifdef LOADER_CYCLE_CNT_EN
      cyc_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      formula_q    <= formula_d;
      clause_idx_q <= clause_idx_d;
      lit_idx_q    <= lit_idx_d;
      find_q       <= find_d;
      done_q       <= done_d;
      res_sat_q    <= res_sat_d;
      res_unsat_q  <= res_unsat_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
`ifdef LOADER_CYCLE_CNT_EN
      cyc_q        <= cyc_d;
`endif
    end
  end

  assign find         = find_q;
  assign out_formula  = formula_q;
  assign done         = done_q;
  assign result_sat   = res_sat_q;
  assign result_unsat = res_unsat_q;
  assign err_code     = err_q;
`ifdef LOADER_CYCLE_CNT_EN
  assign solve_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_formula_loader.sv
// Bench for formula_loader: directed scenarios plus random streams, all checked every cycle
// against a token-level model of the loader. Honours LOADER_CYCLE_CNT_EN if defined.
module tb_formula_loader;
  localparam int unsigned Tmo = 16;
  localparam int          FW  = 234;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          lit_valid = 1'b0, lit_eoc = 1'b0, lit_eof = 1'b0;
  logic [3:0]    lit_in = 4'd0;
  logic          kernel_ended = 1'b0, kernel_sat = 1'b0, kernel_unsat = 1'b0;
  logic          done_ack = 1'b0;
  logic          lit_ready, find, done, result_sat, result_unsat;
  logic [2:0]    err_code;
  logic [FW-1:0] out_formula;
`ifdef LOADER_CYCLE_CNT_EN
  logic [15:0]   solve_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit gaps     = 1'b0;

  formula_loader #(
    .TIMEOUT_CYCLES(Tmo),
    .MAX_CLAUSES   (10),
    .MAX_LITS      (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lit_valid   (lit_valid),
    .lit_ready   (lit_ready),
    .lit_in      (lit_in),
    .lit_eoc     (lit_eoc),
    .lit_eof     (lit_eof),
    .find        (find),
    .out_formula (out_formula),
    .kernel_ended(kernel_ended),
    .kernel_sat  (kernel_sat),
    .kernel_unsat(kernel_unsat),
    .done        (done),
    .result_sat  (result_sat),
    .result_unsat(result_unsat),
    .err_code    (err_code),
    .done_ack    (done_ack)
`ifdef LOADER_CYCLE_CNT_EN
    ,
    .solve_cycles(solve_cycles)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- reference model: phase 0 idle, 1 load, 2 solve, 3 done
  int         m_phase, m_fcnt, m_ncl, m_nlit, m_err, m_age, m_cyc;
  int         m_ccnt [10];
  logic [3:0] m_lit  [10][5];
  bit         m_find, m_done, m_sat, m_unsat;

  task automatic m_clear();
    m_phase = 0; m_fcnt = 0; m_ncl = 0; m_nlit = 0; m_err = 0; m_age = 0; m_cyc = 0;
    m_find = 0; m_done = 0; m_sat = 0; m_unsat = 0;
    for (int c = 0; c < 10; c++) begin
      m_ccnt[c] = 0;
      for (int l = 0; l < 5; l++) m_lit[c][l] = 4'd0;
    end
  endtask

  task automatic m_token(input logic [3:0] lit, input bit eoc, input bit eof);
    int e;
    e = 0;
    if (lit[3:1] == 3'd0) e = 1;
    else if (m_nlit == 5) e = 2;
    else if (m_ncl == 10) e = 3;
    if (e != 0) begin
      m_err = e; m_done = 1; m_phase = 3;
    end else begin
      m_lit[m_ncl][m_nlit] = lit;
      m_nlit++;
      if (eoc || eof) begin
        m_ccnt[m_ncl] = m_nlit;
        m_ncl++;
        m_nlit = 0;
      end
      if (eof) begin
        m_fcnt = m_ncl; m_phase = 2; m_find = 1; m_age = 0; m_cyc = 0;
      end else begin
        m_phase = 1;
      end
    end
  endtask

  function automatic logic [FW-1:0] m_formula();
    logic [FW-1:0] f;
    f = '0;
    f[3:0] = 4'(m_fcnt);
    for (int c = 0; c < 10; c++) begin
      f[4 + 23*c +: 3] = 3'(m_ccnt[c]);
      for (int l = 0; l < 5; l++) f[7 + 23*c + 4*l +: 4] = m_lit[c][l];
    end
    return f;
  endfunction

  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_clear();
    end else begin
      case (m_phase)
        0, 1: if (lit_valid) m_token(lit_in, lit_eoc, lit_eof);
        2: begin
          m_age++;
          if (m_cyc < 65535) m_cyc++;
          if (kernel_ended) begin
            m_sat = kernel_sat; m_unsat = kernel_unsat;
            m_err = (kernel_sat == kernel_unsat) ? 5 : 0;
            m_find = 0; m_done = 1; m_phase = 3;
          end else if (m_age == Tmo) begin
            m_err = 4; m_find = 0; m_done = 1; m_phase = 3;
          end
        end
        3: if (done_ack) m_clear();
        default: ;
      endcase
    end
  end

  // ---------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_f(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      check("lit_ready", 32'(lit_ready), 32'(m_phase < 2));
      check("find", 32'(find), 32'(m_find));
      check("done", 32'(done), 32'(m_done));
      check("result_sat", 32'(result_sat), 32'(m_sat));
      check("result_unsat", 32'(result_unsat), 32'(m_unsat));
      check("err_code", 32'(err_code), 32'(m_err));
      check_f("out_formula", out_formula, m_formula());
`ifdef LOADER_CYCLE_CNT_EN
      check("solve_cycles", 32'(solve_cycles), 32'(m_cyc));
`endif
    end
  end

  // ---------------- stimulus helpers (all called on a falling edge)
  function automatic logic [3:0] lit_of(input int v, input bit pos);
    return {3'(v), pos};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [3:0] lit, input bit eoc, input bit eof, output bit ok);
    if (gaps && $urandom_range(0, 3) == 0) begin
      lit_valid = 1'b0;
      lit_in    = 4'($urandom);
      done_ack  = 1'($urandom_range(0, 1));
      tick(1);
      done_ack  = 1'b0;
    end
    ok = lit_ready;
    if (!ok) begin
      lit_valid = 1'b0;
      return;
    end
    lit_valid = 1'b1; lit_in = lit; lit_eoc = eoc; lit_eof = eof;
    tick(1);
    lit_valid = 1'b0; lit_eoc = 1'b0; lit_eof = 1'b0;
  endtask

  task automatic kernel(input bit s, input bit u);
    kernel_ended = 1'b1; kernel_sat = s; kernel_unsat = u;
    tick(1);
    kernel_ended = 1'b0; kernel_sat = 1'b0; kernel_unsat = 1'b0;
  endtask

  task automatic ack();
    done_ack = 1'b1;
    tick(1);
    done_ack = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic run_random();
    int ncl, nl, rst_at, tok, d, r;
    bit ok;
    logic [2:0] v;
    ncl    = ($urandom_range(0, 7) == 0) ? 11 : int'($urandom_range(1, 10));
    rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 8)) : -1;
    tok    = 0;
    ok     = 1'b1;
    for (int c = 0; c < ncl && ok; c++) begin
      nl = ($urandom_range(0, 15) == 0) ? 6 : int'($urandom_range(1, 5));
      for (int l = 0; l < nl && ok; l++) begin
        v = ($urandom_range(0, 39) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        if (tok == rst_at) begin
          pulse_reset();
          return;
        end
        send({v, 1'($urandom_range(0, 1))}, l == nl - 1, (l == nl - 1) && (c == ncl - 1), ok);
        tok++;
      end
    end
    if (find) begin
      d = $urandom_range(0, 20);
      for (int i = 0; i < d; i++) begin
        lit_valid = 1'($urandom_range(0, 1));
        lit_in    = 4'($urandom);
        lit_eoc   = 1'($urandom_range(0, 1));
        tick(1);
      end
      lit_valid = 1'b0; lit_eoc = 1'b0;
      r = $urandom_range(0, 9);
      kernel((r < 4) || (r == 8), (r >= 4) && (r <= 8));
    end
    for (int i = 0; i < 60 && !done; i++) tick(1);
    check("done within bound", 32'(done), 32'd1);
    tick($urandom_range(0, 3));
    ack();
    if (!lit_ready) pulse_reset();
  endtask

  // ---------------- main sequence
  initial begin
    bit ok;
    int cnt;
    tick(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset lit_ready", 32'(lit_ready), 32'd1);
    check("reset find", 32'(find), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_f("reset out_formula", out_formula, '0);

    // (x1 v x2)(~x1)(~x2 v x3 v ~x5), sat verdict 5 cycles after find
    send(lit_of(1, 1), 0, 0, ok); send(lit_of(2, 1), 1, 0, ok);
    send(lit_of(1, 0), 1, 0, ok);
    send(lit_of(2, 0), 0, 0, ok); send(lit_of(3, 1), 0, 0, ok); send(lit_of(5, 0), 1, 1, ok);
    check("t1 find after eof", 32'(find), 32'd1);
    check("t1 formula count", 32'(out_formula[3:0]), 32'd3);
    check("t1 clause0 count", 32'(out_formula[6:4]), 32'd2);
    check("t1 clause1 count", 32'(out_formula[29:27]), 32'd1);
    check("t1 clause2 count", 32'(out_formula[52:50]), 32'd3);
    check("t1 c0 lit0", 32'(out_formula[10:7]), 32'h3);
    check("t1 c2 lit2", 32'(out_formula[64:61]), 32'ha);
    check("t1 c2 lit3 empty", 32'(out_formula[68:65]), 32'd0);
    tick(4);
    kernel(1, 0);
    check("t1 done", 32'(done), 32'd1);
    check("t1 result_sat", 32'(result_sat), 32'd1);
    check("t1 err_code", 32'(err_code), 32'd0);
`ifdef LOADER_CYCLE_CNT_EN
    check("t1 solve_cycles", 32'(solve_cycles), 32'd5);
`endif
    ack();

    // (x1)(~x1), unsat
    send(lit_of(1, 1), 1, 0, ok); send(lit_of(1, 0), 1, 1, ok);
    kernel(0, 1);
    check("t2 result_unsat", 32'(result_unsat), 32'd1);
    check("t2 result_sat", 32'(result_sat), 32'd0);
    check("t2 find low", 32'(find), 32'd0);
    ack();
    check_f("t2 formula cleared", out_formula, '0);
    check("t2 back to idle", 32'(lit_ready), 32'd1);

    // six literals in one clause
    for (int i = 0; i < 6; i++) send(lit_of(i + 1, 1), 0, 0, ok);
    check("t3 err clause ovf", 32'(err_code), 32'd2);
    check("t3 lit_ready low", 32'(lit_ready), 32'd0);
    tick(3);
    check("t3 find never", 32'(find), 32'd0);
    ack();

    // eleven clauses, then a var-0 token
    for (int i = 0; i < 11; i++) send(lit_of(1, i[0]), 1, 0, ok);
    check("t4 err formula ovf", 32'(err_code), 32'd3);
    ack();
    send(4'b0001, 0, 0, ok);
    check("t4 err bad var", 32'(err_code), 32'd1);
    ack();

    // timeout, then protocol error
    send(lit_of(3, 1), 1, 1, ok);
    cnt = 0;
    while (find && cnt < 40) begin
      tick(1);
      cnt++;
    end
    check("t5 find high cycles", 32'(cnt), 32'd16);
    check("t5 err timeout", 32'(err_code), 32'd4);
    ack();
    send(lit_of(4, 0), 1, 1, ok);
    tick(2);
    kernel(1, 1);
    check("t5 err proto", 32'(err_code), 32'd5);
    check("t5 proto sat latched", 32'(result_sat), 32'd1);
    ack();

    // reset mid-SOLVE and mid-LOAD
    send(lit_of(1, 1), 1, 1, ok);
    tick(2);
    pulse_reset();
    check("t6 solve reset find", 32'(find), 32'd0);
    check_f("t6 solve reset formula", out_formula, '0);
    send(lit_of(2, 1), 0, 0, ok); send(lit_of(3, 0), 1, 0, ok);
    pulse_reset();
    check("t6 load reset lit_ready", 32'(lit_ready), 32'd1);
    check("t6 load reset done", 32'(done), 32'd0);
    send(lit_of(7, 1), 1, 1, ok);
    check("t6 fresh count", 32'(out_formula[3:0]), 32'd1);
    check("t6 fresh lit", 32'(out_formula[10:7]), 32'hf);
    tick(1);
    kernel(0, 1);
    check("t6 fresh unsat", 32'(result_unsat), 32'd1);
    ack();

    gaps = 1'b1;
    for (int t = 0; t < 150; t++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
